sistema_cpu_debug_scan_master: RTL

Single-clock JTAG scan initiator for the Nios II debug slave. It drives the virtual-JTAG side of the CPU debug slave (tck, tdi, ir_in, uir/cdr/sdr/udr/rti strobes) and captures tdo and ir_out. Each accepted command becomes one complete IR+DR scan, and the 38-bit shifted-out word is returned. It lets simulation benches and an on-chip debug master exercise the debug slave without a physical TAP.

---
 rtl/sistema_cpu_debug_scan_master.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sistema_cpu_debug_scan_master.sv
// Single-clock virtual-JTAG scan initiator for the Nios II debug slave.
// Each accepted command runs one UIR(optional)/CDR/SDR/UDR sequence and returns the captured DR word.
module sistema_cpu_debug_scan_master #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_HALF = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic                cmd_skip_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned PH_W  = 8;
  localparam int unsigned BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR} state_t;

  state_t              state, state_nxt;
  logic [PH_W-1:0]     phase, phase_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [DR_WIDTH-1:0] tx, tx_nxt;
  logic [DR_WIDTH-1:0] rx, rx_nxt;
  logic                tck_nxt, tdi_nxt, rsp_valid_nxt;
  logic [DR_WIDTH-1:0] rsp_data_nxt;
  logic [IR_WIDTH-1:0] rsp_ir_out_nxt, ir_in_nxt;
  logic                half_end, rise, fall;

  assign cmd_ready = (state == S_IDLE);
  assign half_end  = (phase == PH_W'(TCK_HALF - 1));
  // rise/fall mark the clk edges on which tck is driven 0->1 / 1->0
  assign rise      = half_end & ~vji_tck;
  assign fall      = half_end & vji_tck;

  always_comb begin
    state_nxt      = state;
    phase_nxt      = '0;
    tck_nxt        = 1'b0;
    bit_nxt        = bit_cnt;
    tx_nxt         = tx;
    rx_nxt         = rx;
    ir_in_nxt      = vji_ir_in;
    rsp_valid_nxt  = 1'b0;
    rsp_data_nxt   = rsp_data;
    rsp_ir_out_nxt = rsp_ir_out;

    if (state != S_IDLE) begin
      phase_nxt = half_end ? '0 : phase + PH_W'(1);
      tck_nxt   = half_end ? ~vji_tck : vji_tck;
    end

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = cmd_skip_ir ? S_CDR : S_UIR;
          tx_nxt    = cmd_data;
          bit_nxt   = '0;
          if (!cmd_skip_ir) ir_in_nxt = cmd_ir;
        end
      end
      S_UIR: if (fall) state_nxt = S_CDR;
      S_CDR: begin
        if (rise) rsp_ir_out_nxt = vji_ir_out;
        if (fall) begin
          state_nxt = S_SDR;
          bit_nxt   = '0;
        end
      end
      S_SDR: begin
        // tdo is taken before the slave's own posedge shift
        if (rise) rx_nxt = {vji_tdo, rx[DR_WIDTH-1:1]};
        if (fall) begin
          tx_nxt = tx >> 1;
          if (bit_cnt == BIT_W'(DR_WIDTH - 1)) state_nxt = S_UDR;
          else bit_nxt = bit_cnt + BIT_W'(1);
        end
      end
      S_UDR: begin
        if (fall) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = rx;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    tdi_nxt = (state_nxt == S_SDR) ? tx_nxt[0] : 1'b0;
  end

  // Strobes are registered from the next state so they track it without glitches
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      tx         <= '0;
      rx         <= '0;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      bit_cnt    <= bit_nxt;
      tx         <= tx_nxt;
      rx         <= rx_nxt;
      vji_tck    <= tck_nxt;
      vji_tdi    <= tdi_nxt;
      vji_ir_in  <= ir_in_nxt;
      vji_uir    <= (state_nxt == S_UIR);
      vji_cdr    <= (state_nxt == S_CDR);
      vji_sdr    <= (state_nxt == S_SDR);
      vji_udr    <= (state_nxt == S_UDR);
      vji_rti    <= (state_nxt == S_IDLE);
      rsp_valid  <= rsp_valid_nxt;
      rsp_data   <= rsp_data_nxt;
      rsp_ir_out <= rsp_ir_out_nxt;
    end
  end

endmodule
